muldiv: RTL and testbench
=========================

# muldiv

Iterative multiply/divide unit for the MIPS datapath; it owns the HI/LO registers. Operands come straight from the register file's two read ports (rs → `a`, rt → `b`). `hi`/`lo` feed the writeback mux that drives register-file `data_write` for mfhi/mflo. One operation is in flight at a time, and control stalls the pipeline while `busy` is high.

## Interface
- No parameters; width fixed at 32, iteration count fixed at 32.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled with `op`, `a`, `b` on the rising edge.
- `op`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved.
- `a`  in  32  rs operand (multiplicand / dividend / mthi-mtlo source).
- `b`  in  32  rt operand (multiplier / divisor).
- `busy`  out  1  operation in progress; new requests ignored.
- `done`  out  1  one-cycle pulse: HI/LO just updated by mult/div.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Reset, with priority over everything: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- States:
  - IDLE → MUL on an accepted mult/multu.
  - IDLE → DIV on an accepted div/divu.
  - MUL/DIV → FIN after 32 iterations.
  - FIN → IDLE.
- A request is accepted only when `start`=1 and `busy`=0. A request with `busy`=1 or a reserved `op` is dropped with no state change.
- mthi/mtlo: `hi` (or `lo`) ← `a` on the accepting edge. `busy` stays 0, no `done`, no state change.
- On accept of mult/div:
  - Latch operand magnitudes.
  - Signed ops: take the absolute value of each operand and record the result signs.
  - Unsigned ops: operands used as-is.
- MUL: radix-2 shift-add, one iteration per cycle, 64-bit product accumulator.
- DIV: restoring division, one quotient bit per cycle, 33-bit partial remainder.
- FIN: apply sign correction, write `hi`/`lo`, pulse `done`.
- Results:
  - mult/multu: {hi,lo} = 64-bit product.
  - div/divu: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - Signed quotient is negative iff the operand signs differ.
- Divide by zero, div or divu: `hi` = `a` as latched, `lo` = 0xFFFFFFFF. Latency is unchanged.
- div 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0 (natural wrap, no trap).
- `hi`/`lo` hold their old values for the whole operation. mfhi during `busy` reads the stale value; stalling is the control unit's job.
- Reset mid-operation aborts the operation; HI/LO are cleared.

## Timing
- Accept edge E0 → `busy`=1 from just after E0 through the edge E33.
- Iterations occur on edges E1..E32. E33 is the FIN edge: `hi`/`lo` update, `done`=1 for the cycle after E33, `busy`=0.
- Latency: 33 cycles from accept to valid HI/LO. Back-to-back ops: the next `start` can be accepted on E34 (the `done` cycle counts as idle).
- mthi/mtlo: 1 cycle; value is visible after the accepting edge.
- `done` is never high for two consecutive cycles. `busy` and `done` are never both high.

## Test plan
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → after E33: hi=0xFFFFFFFE, lo=0x00000001. `busy` high exactly 33 cycles; `done` single pulse.
- mult a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. mult a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 → lo=3, hi=1. divu a=0xFFFFFFF9, b=2 → lo=0x7FFFFFFC, hi=1.
- Edge cases:
  - divu a=0x12345678, b=0 → hi=0x12345678, lo=0xFFFFFFFF after 33 cycles.
  - div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Busy and move handling:
  - Issue multu 3×5, then assert mtlo a=0xAAAA and divu at E5 and E10 → both ignored; final hi=0, lo=15.
  - mthi a=0x1234 in IDLE → hi=0x1234 next edge, `busy`/`done` stay 0.
- Reset and back-to-back:
  - Start mult 6×7, assert `reset` at E10 → after E10: busy=0, hi=lo=0, no `done`.
  - A following multu 6×7 gives lo=42, hi=0. A divu started in its `done` cycle is accepted.

Source files
------------

// File: rtl/muldiv.sv
// muldiv: iterative 32-bit multiply/divide unit owning the HI/LO registers.
// Ports:
//   clock_i  rising-edge clock
//   reset_i  synchronous active-high reset, clears HI/LO and aborts any operation
//   start_i  request strobe, sampled with op_i/a_i/b_i; honoured only while idle
//   op_i     000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x reserved
//   a_i      rs operand (multiplicand / dividend / move source)
//   b_i      rt operand (multiplier / divisor)
//   busy_o   multiply or divide in progress
//   done_o   one-cycle pulse after HI/LO are written by a multiply or divide
//   hi_o     HI register
//   lo_o     LO register
module muldiv (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3;
    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier bits}; DIV: low half shifts dividend out, quotient in
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    // multiplicand magnitude for MUL, divisor magnitude for DIV
    logic [31:0] opnd_q, opnd_d;
    logic        is_div_q, is_div_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;
    logic        sgn;
    logic [31:0] abs_a, abs_b;
    logic [32:0] add_sum, shifted, diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign sgn      = ~op_i[0];
    assign abs_a    = (sgn && a_i[31]) ? -a_i : a_i;
    assign abs_b    = (sgn && b_i[31]) ? -b_i : b_i;
    assign add_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    // 33-bit partial remainder; bit 32 of the difference is the borrow that selects restore
    assign shifted  = {rem_q, acc_q[31]};
    assign diff     = shifted - {1'b0, opnd_q};
    assign prod_fix = qneg_q ? -acc_q : acc_q;
    assign quo_fix  = qneg_q ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix  = rneg_q ? -rem_q : rem_q;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                if (op_i == 3'b100) hi_d = a_i;
                else if (op_i == 3'b101) lo_d = a_i;
                else if (!op_i[2]) begin
                    state_d  = op_i[1] ? DIV : MUL;
                    cnt_d    = 5'd0;
                    acc_d    = {32'd0, op_i[1] ? abs_a : abs_b};
                    opnd_d   = op_i[1] ? abs_b : abs_a;
                    rem_d    = 32'd0;
                    is_div_d = op_i[1];
                    qneg_d   = sgn & (a_i[31] ^ b_i[31]);
                    rneg_d   = sgn & a_i[31];
                    dz_d     = op_i[1] & (b_i == 32'd0);
                end
            end
            MUL: begin
                acc_d   = acc_q[0] ? {add_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd31) ? FIN : MUL;
            end
            DIV: begin
                acc_d   = {acc_q[63:32], acc_q[30:0], ~diff[32]};
                rem_d   = diff[32] ? shifted[31:0] : diff[31:0];
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd31) ? FIN : DIV;
            end
            default: begin
                // divide by zero leaves |a| in the remainder, so sign correction restores a itself
                hi_d    = is_div_q ? rem_fix : prod_fix[63:32];
                lo_d    = is_div_q ? (dz_q ? 32'hFFFF_FFFF : quo_fix) : prod_fix[31:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            rem_q    <= 32'd0;
            opnd_q   <= 32'd0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: randomized and directed self-checking bench for muldiv against an arithmetic model.
module tb_muldiv;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        busy, done, done_prev = 1'b0;
    logic [31:0] hi, lo;
    logic [31:0] hi_m = 32'd0, lo_m = 32'd0;
    int          checks = 0, errors = 0;

    muldiv dut (
        .clock_i(clock), .reset_i(reset), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (o[1] && y == 32'd0) return {x, 32'hFFFF_FFFF};
        case (o)
            3'd0: return 64'(sx * sy);
            3'd1: return ux * uy;
            3'd2: begin
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: return {32'(ux % uy), 32'(ux / uy)};
        endcase
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            check("busy_done_excl", {63'd0, busy & done}, 64'd0);
            check("done_single", {63'd0, done & done_prev}, 64'd0);
        end
        done_prev <= done;
    end

    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clock);
        start = 1'b0;
        check("done_low_after_accept", {63'd0, done}, 64'd0);
    endtask

    task automatic wait_done(input logic [63:0] e, input int exp_busy);
        int nb, k;
        bit seen, stale;
        nb = 0; k = 0; seen = 0; stale = 1;
        while (!seen && k < 80) begin
            if (done) seen = 1;
            else begin
                if (busy) nb++;
                if (hi !== hi_m || lo !== lo_m) stale = 0;
                @(negedge clock);
                k++;
            end
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        check("busy_cycles", 64'(nb), 64'(exp_busy));
        check("stale_hilo", {63'd0, stale}, 64'd1);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("lo", {32'd0, lo}, {32'd0, e[31:0]});
        hi_m = e[63:32];
        lo_m = e[31:0];
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clock);
        launch(o, x, y);
        wait_done(model(o, x, y), 33);
    endtask

    task automatic move(input logic [2:0] o, input logic [31:0] x);
        @(negedge clock);
        start = 1'b1; op = o; a = x;
        @(negedge clock);
        start = 1'b0;
        if (o == 3'b100) hi_m = x;
        if (o == 3'b101) lo_m = x;
        check("move_busy", {63'd0, busy}, 64'd0);
        check("move_done", {63'd0, done}, 64'd0);
        check("move_hi", {32'd0, hi}, {32'd0, hi_m});
        check("move_lo", {32'd0, lo}, {32'd0, lo_m});
    endtask

    initial begin
        logic [63:0] e;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        bit          saw;
        repeat (2) @(negedge clock);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        do_op(3'd0, 32'h8000_0000, 32'h8000_0000);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd3, 32'd7, 32'd2);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd3, 32'h1234_5678, 32'd0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd2, 32'hFFFF_FFF0, 32'd0);
        move(3'b100, 32'h1234);
        move(3'b101, 32'h5678);
        move(3'b110, 32'hDEAD);
        move(3'b111, 32'hBEEF);
        @(negedge clock);
        launch(3'd1, 32'd3, 32'd5);
        repeat (4) @(negedge clock);
        start = 1'b1; op = 3'b101; a = 32'hAAAA;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        wait_done(model(3'd1, 32'd3, 32'd5), 23);
        move(3'b100, 32'h0BAD_F00D);
        @(negedge clock);
        launch(3'd0, 32'd6, 32'd7);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        saw = 0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) saw = 1;
        end
        check("rst_no_activity", {63'd0, saw}, 64'd0);
        do_op(3'd1, 32'd6, 32'd7);
        launch(3'd3, 32'd100, 32'd7);
        wait_done(model(3'd3, 32'd100, 32'd7), 33);
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 5));
            rx = $urandom;
            ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) ry = {{28{ry[31]}}, ry[3:0]};
            if (ro < 3'd4) do_op(ro, rx, ry);
            else move(ro, rx);
        end
        e = model(3'd2, 32'd0, 32'd5);
        do_op(3'd2, 32'd0, 32'd5);
        check("zero_div_lo", {32'd0, lo}, {32'd0, e[31:0]});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
